// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the async FIFO write port plus flush sequencing (clk_in domain).
// Optional macro FIFO_ARB_BURST_LIMIT_EN caps each grant at MAX_BURST accepted words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int mem_width    = 32,
  parameter int MAX_BURST    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*mem_width-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic                         flush_req,
  input  logic                         full,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         insert,
  output logic [mem_width-1:0]         data_in,
  output logic                         flush,
  output logic                         busy
);
  // state   | meaning
  // S_IDLE  | no requester owns the write port
  // S_GRANT | requester gnt_id owns the port until its packet (or burst) ends
  // S_FLUSH | flush held high for FLUSH_CYCLES cycles

  localparam int IDW = $clog2(NUM_REQ);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (NUM_REQ < 2 || FLUSH_CYCLES < 1 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_FLUSH} state_t;

  state_t               state;
  logic [IDW-1:0]       gnt_id;
  logic [IDW-1:0]       last_id;
  logic [IDW-1:0]       pick_id;
  logic                 pick_vld;
  logic                 flush_pend;
  logic [FCW-1:0]       flush_cnt;
  logic                 owner_req;
  logic                 owner_last;
  logic [mem_width-1:0] owner_data;
  logic                 burst_hit;

  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        owner_req  = req[i];
        owner_last = req_last[i];
        owner_data = req_data[i*mem_width +: mem_width];
      end
    end
  end

  // Scan last_id+1, last_id+2, ... and take the first requester found.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = last_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_vld && req[j] && (j == (int'(last_id) + k) % NUM_REQ)) begin
          pick_vld = 1'b1;
          pick_id  = IDW'(j);
        end
      end
    end
  end

  assign insert  = (state == S_GRANT) & owner_req & ~full;
  assign ack     = grant & {NUM_REQ{insert}};
  assign data_in = insert ? owner_data : '0;
  assign busy    = (state != S_IDLE) | flush_pend;

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int BCW = $clog2(MAX_BURST + 1);
  logic [BCW-1:0] burst_cnt;

  assign burst_hit = (burst_cnt == BCW'(MAX_BURST - 1));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (state != S_GRANT) begin
      burst_cnt <= '0;
    end else if (insert) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      gnt_id     <= '0;
      last_id    <= IDW'(NUM_REQ - 1);
      flush_pend <= 1'b0;
      flush      <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_req || flush_pend) begin
            state      <= S_FLUSH;
            flush      <= 1'b1;
            flush_cnt  <= FCW'(FLUSH_CYCLES - 1);
            flush_pend <= 1'b0;
          end else if (pick_vld) begin
            state   <= S_GRANT;
            grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            gnt_id  <= pick_id;
            last_id <= pick_id;
          end
        end
        S_GRANT: begin
          if (flush_req) begin
            flush_pend <= 1'b1;
          end
          // A stalled or absent owner keeps the port: packets never interleave.
          if (insert && (owner_last || burst_hit)) begin
            state <= S_IDLE;
            grant <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= S_IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter and sequencer for the asynchronous FIFO, running entirely in the `clk_in` domain. It shares the FIFO's single write port (`insert`, `data_in`) among `NUM_REQ` packet-oriented requesters using round-robin arbitration, and backpressures them with the FIFO's `full` flag. It also owns the FIFO `flush` input, issuing flush pulses only at packet boundaries.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥2.
- `mem_width`, 32: data word width; matches the FIFO data width.
- `MAX_BURST`, 16: maximum words per grant; used only when `FIFO_ARB_BURST_LIMIT_EN` is defined.
- `FLUSH_CYCLES`, 2: number of cycles `flush` is held high; must be ≥1.

Ports:
- `clk_in`  in  1  write-domain clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester word-valid.
- `req_data`  in  NUM_REQ*mem_width  packed words; requester i occupies bits [i*mem_width +: mem_width].
- `req_last`  in  NUM_REQ  marks the final word of a packet; qualified by `req`.
- `flush_req`  in  1  single-cycle flush request pulse.
- `full`  in  1  FIFO full flag.
- `grant`  out  NUM_REQ  one-hot current owner; all zeros when no requester owns the port.
- `ack`  out  NUM_REQ  word accepted this cycle; at most one bit set.
- `insert`  out  1  FIFO write strobe.
- `data_in`  out  mem_width  FIFO write data.
- `flush`  out  1  FIFO flush.
- `busy`  out  1  high while in the GRANT or FLUSH state, or while a flush is pending.

## Operation
- States:
  - IDLE: no requester owns the port.
  - GRANT: one requester owns the port.
  - FLUSH: `flush` is being driven high.
- Round-robin pointer `last_id`:
  - Resets to NUM_REQ-1, so requester 0 wins first.
  - Updated to the winner's index on every grant.
- IDLE:
  - If `flush_req` is high or a flush is pending, go to FLUSH. Flush has priority over new grants.
  - Otherwise, if any `req` bit is set, pick the first set bit scanning last_id+1, last_id+2, … modulo NUM_REQ. Register a one-hot `grant` and go to GRANT.
- GRANT (owner g):
  - `insert = req[g] & ~full`, computed combinationally.
  - `ack[g] = insert`.
  - `data_in` = slice g of `req_data` when `insert` is high; otherwise 0.
  - An accepted word with `req_last[g]` set ends the packet: clear `grant` and go to IDLE.
  - If `req[g]` deasserts mid-packet, keep the grant (packet lock). No other requester may interleave.
- Flush handling:
  - `flush_req` seen in GRANT sets the `flush_pend` register. The flush is serviced from IDLE after the current packet ends.
  - A second `flush_req` while a flush is pending or in progress is merged into it.
- FLUSH:
  - `flush` is high for exactly FLUSH_CYCLES cycles, using a down-counter.
  - `insert` and `grant` are 0 throughout.
  - `flush_pend` clears on entry to FLUSH.
  - Returns to IDLE afterwards. `last_id` is unchanged.
- `full` high: no `ack`, no `insert`. The grant is held indefinitely.
- Reset (async assert, mid-operation included): state goes to IDLE immediately, and the following values apply:
  - `grant`=0, `ack`=0, `insert`=0, `data_in`=0.
  - `flush`=0, `busy`=0, `flush_pend`=0, `last_id`=NUM_REQ-1.
  - A partially written packet is abandoned. The FIFO contents are not this block's responsibility.

## Timing
- Arbitration latency: `req` seen in IDLE at cycle N → `grant` at N+1 → first `ack`/`insert` at N+1 if `full` is low.
- Throughput: 1 word/cycle within a packet.
- One IDLE bubble cycle between consecutive packets.
- `insert`, `ack` and `data_in` are combinational from `req`, `full` and registered `grant`. Requesters must hold `req`, `data` and `last` stable until they see `ack`.
- `flush_req` in IDLE at cycle N → `flush` high for cycles N+1 … N+FLUSH_CYCLES → IDLE at N+FLUSH_CYCLES+1.
- `flush` is a registered output.

## Configuration
- `FIFO_ARB_BURST_LIMIT_EN` defined:
  - A burst counter counts `ack`s per grant.
  - When the MAX_BURST-th word is accepted without `req_last`, the grant is released to IDLE and the pointer has already advanced, so other requesters can win.
  - The interrupted packet resumes when the requester is next granted.
  - The counter clears on every grant.
- `FIFO_ARB_BURST_LIMIT_EN` undefined:
  - No counter exists.
  - The grant is held until `req_last`, regardless of packet length.

## Test plan
- Reset release, `req`=4'b0101, 3-word packets → grant order 0, 2, 0, 2. Each packet gives 3 `ack`s on consecutive cycles with one IDLE gap, and `data_in` matches the owner's words.
- All four requesters asserting continuously with 1-word packets → `grant` sequence 0, 1, 2, 3, 0, and `ack` is never on two requesters at once.
- `full` high for 5 cycles mid-packet → `insert`=0 for those cycles, grant held, and no word lost or duplicated after `full` falls.
- `flush_req` on the 2nd word of a 4-word packet → packet completes (4 `ack`s), then `flush` high for 2 cycles with `insert`=0, then arbitration resumes.
- `reset` asserted mid-packet (asynchronously, between clock edges) → `grant`, `insert` and `flush` drop immediately. After release, requester 0 wins first.
- With `FIFO_ARB_BURST_LIMIT_EN` and MAX_BURST=4: requester 0 sends a 10-word packet while requester 1 is pending → requester 0 gets 4 words, requester 1 gets its packet, then requester 0 resumes with its 5th word.
